// File: rtl/tl_buf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tl_buf_pkg: TileLink-UL A/D beat structs and sizing helper        |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package tl_buf_pkg;

    localparam int TL_ADDR_W  = 32;
    localparam int TL_DATA_W  = 32;
    localparam int TL_MASK_W  = TL_DATA_W / 8;
    localparam int TL_SIZE_W  = 3;
    localparam int TL_SRC_W   = 2;
    localparam int TL_SINK_W  = 1;
    localparam int TL_OP_W    = 3;
    localparam int TL_PARAM_W = 3;

    typedef struct packed {
        logic [TL_OP_W-1:0]    opcode;
        logic [TL_PARAM_W-1:0] param;
        logic [TL_SIZE_W-1:0]  size;
        logic [TL_SRC_W-1:0]   source;
        logic [TL_ADDR_W-1:0]  address;
        logic [TL_MASK_W-1:0]  mask;
        logic [TL_DATA_W-1:0]  data;
    } tl_a_t;

    typedef struct packed {
        logic [TL_OP_W-1:0]    opcode;
        logic [TL_PARAM_W-1:0] param;
        logic [TL_SIZE_W-1:0]  size;
        logic [TL_SRC_W-1:0]   source;
        logic [TL_SINK_W-1:0]  sink;
        logic [TL_DATA_W-1:0]  data;
        logic                  error;
    } tl_d_t;

    // Occupancy needs one bit more than the index so "full" is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tl_sync_fifo: first-word-fall-through FIFO, wrap-bit pointers     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tl_sync_fifo
    import tl_buf_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign count    = wr_ptr - rd_ptr;
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr[PTR_W-2:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[PTR_W-2:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/tilelink_channel_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tilelink_channel_buffer: A/D FIFOs with outstanding-request cap;  |
// | optional perf counters under `TL_BUF_PERF_EN. rev 1.0             |
// +------------------------------------------------------------------+
module tilelink_channel_buffer
    import tl_buf_pkg::*;
#(
    parameter int ADDR_WIDTH      = TL_ADDR_W,
    parameter int DATA_WIDTH      = TL_DATA_W,
    parameter int MASK_WIDTH      = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH      = TL_SIZE_W,
    parameter int SRC_WIDTH       = TL_SRC_W,
    parameter int SINK_WIDTH      = TL_SINK_W,
    parameter int OPCODE_WIDTH    = TL_OP_W,
    parameter int PARAM_WIDTH     = TL_PARAM_W,
    parameter int A_DEPTH         = 4,
    parameter int D_DEPTH         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_valid_in,
    output logic                    a_ready_in,
    input  logic [OPCODE_WIDTH-1:0] a_opcode_in,
    input  logic [PARAM_WIDTH-1:0]  a_param_in,
    input  logic [SIZE_WIDTH-1:0]   a_size_in,
    input  logic [SRC_WIDTH-1:0]    a_source_in,
    input  logic [ADDR_WIDTH-1:0]   a_address_in,
    input  logic [MASK_WIDTH-1:0]   a_mask_in,
    input  logic [DATA_WIDTH-1:0]   a_data_in,
    output logic                    a_valid_out,
    input  logic                    a_ready_out,
    output logic [OPCODE_WIDTH-1:0] a_opcode_out,
    output logic [PARAM_WIDTH-1:0]  a_param_out,
    output logic [SIZE_WIDTH-1:0]   a_size_out,
    output logic [SRC_WIDTH-1:0]    a_source_out,
    output logic [ADDR_WIDTH-1:0]   a_address_out,
    output logic [MASK_WIDTH-1:0]   a_mask_out,
    output logic [DATA_WIDTH-1:0]   a_data_out,
    input  logic                    d_valid_in,
    output logic                    d_ready_in,
    input  logic [OPCODE_WIDTH-1:0] d_opcode_in,
    input  logic [PARAM_WIDTH-1:0]  d_param_in,
    input  logic [SIZE_WIDTH-1:0]   d_size_in,
    input  logic [SRC_WIDTH-1:0]    d_source_in,
    input  logic [SINK_WIDTH-1:0]   d_sink_in,
    input  logic [DATA_WIDTH-1:0]   d_data_in,
    input  logic                    d_error_in,
    output logic                    d_valid_out,
    input  logic                    d_ready_out,
    output logic [OPCODE_WIDTH-1:0] d_opcode_out,
    output logic [PARAM_WIDTH-1:0]  d_param_out,
    output logic [SIZE_WIDTH-1:0]   d_size_out,
    output logic [SRC_WIDTH-1:0]    d_source_out,
    output logic [SINK_WIDTH-1:0]   d_sink_out,
    output logic [DATA_WIDTH-1:0]   d_data_out,
    output logic                    d_error_out,
    output logic [7:0]              outstanding,
    output logic                    idle,
    output logic                    err_unexpected_d,
    input  logic                    err_clr,
    input  logic                    perf_clr,
    output logic [7:0]              a_hwm,
    output logic [7:0]              d_hwm,
    output logic [15:0]             a_stall_cnt
);

    localparam int         A_CNT_W = occ_width(A_DEPTH);
    localparam int         D_CNT_W = occ_width(D_DEPTH);
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    tl_a_t               a_in_pkt, a_out_pkt;
    tl_d_t               d_in_pkt, d_out_pkt;
    logic                a_full, a_empty, a_push, a_pop, a_fire;
    logic                d_full, d_empty, d_push, d_pop, d_fire;
    logic [A_CNT_W-1:0]  a_count, a_cnt_next;
    logic [D_CNT_W-1:0]  d_count, d_cnt_next;
    logic [7:0]          outstanding_next;

    assign a_in_pkt = '{opcode: a_opcode_in, param: a_param_in, size: a_size_in,
                        source: a_source_in, address: a_address_in,
                        mask: a_mask_in, data: a_data_in};
    assign d_in_pkt = '{opcode: d_opcode_in, param: d_param_in, size: d_size_in,
                        source: d_source_in, sink: d_sink_in,
                        data: d_data_in, error: d_error_in};

    assign a_ready_in  = !a_full;
    assign d_ready_in  = !d_full;
    assign a_push      = a_valid_in && a_ready_in;
    assign d_push      = d_valid_in && d_ready_in;
    assign a_valid_out = !a_empty && (outstanding < MAX_OUT);
    assign d_valid_out = !d_empty;
    assign a_fire      = a_valid_out && a_ready_out;
    assign d_fire      = d_valid_out && d_ready_out;
    assign a_pop       = a_fire;
    assign d_pop       = d_fire;

    tl_sync_fifo #(.WIDTH($bits(tl_a_t)), .DEPTH(A_DEPTH)) u_a_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(a_push), .push_data(a_in_pkt),
        .pop(a_pop), .pop_data(a_out_pkt),
        .full(a_full), .empty(a_empty), .count(a_count)
    );

    tl_sync_fifo #(.WIDTH($bits(tl_d_t)), .DEPTH(D_DEPTH)) u_d_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(d_push), .push_data(d_in_pkt),
        .pop(d_pop), .pop_data(d_out_pkt),
        .full(d_full), .empty(d_empty), .count(d_count)
    );

    assign a_opcode_out  = a_out_pkt.opcode;
    assign a_param_out   = a_out_pkt.param;
    assign a_size_out    = a_out_pkt.size;
    assign a_source_out  = a_out_pkt.source;
    assign a_address_out = a_out_pkt.address;
    assign a_mask_out    = a_out_pkt.mask;
    assign a_data_out    = a_out_pkt.data;
    assign d_opcode_out  = d_out_pkt.opcode;
    assign d_param_out   = d_out_pkt.param;
    assign d_size_out    = d_out_pkt.size;
    assign d_source_out  = d_out_pkt.source;
    assign d_sink_out    = d_out_pkt.sink;
    assign d_data_out    = d_out_pkt.data;
    assign d_error_out   = d_out_pkt.error;

    // Post-edge occupancies let idle and the high-water marks track the same state.
    assign a_cnt_next = a_count + A_CNT_W'(a_push) - A_CNT_W'(a_pop);
    assign d_cnt_next = d_count + D_CNT_W'(d_push) - D_CNT_W'(d_pop);

    always_comb begin
        outstanding_next = outstanding;
        if (a_fire && !d_fire)
            outstanding_next = outstanding + 8'd1;
        else if (!a_fire && d_fire && outstanding != 8'd0)
            outstanding_next = outstanding - 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding      <= 8'd0;
            idle             <= 1'b1;
            err_unexpected_d <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            idle        <= (a_cnt_next == '0) && (d_cnt_next == '0) &&
                           (outstanding_next == 8'd0);
            if (d_fire && outstanding == 8'd0)
                err_unexpected_d <= 1'b1;
            else if (err_clr)
                err_unexpected_d <= 1'b0;
        end
    end

`ifdef TL_BUF_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_hwm       <= 8'd0;
            d_hwm       <= 8'd0;
            a_stall_cnt <= 16'd0;
        end else if (perf_clr) begin
            a_hwm       <= 8'd0;
            d_hwm       <= 8'd0;
            a_stall_cnt <= 16'd0;
        end else begin
            if (8'(a_cnt_next) > a_hwm) a_hwm <= 8'(a_cnt_next);
            if (8'(d_cnt_next) > d_hwm) d_hwm <= 8'(d_cnt_next);
            if (a_valid_in && !a_ready_in && a_stall_cnt != 16'hFFFF)
                a_stall_cnt <= a_stall_cnt + 16'd1;
        end
    end
`else
    logic perf_clr_unused;
    assign perf_clr_unused = perf_clr;
    assign a_hwm           = 8'd0;
    assign d_hwm           = 8'd0;
    assign a_stall_cnt     = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tilelink_channel_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tilelink_channel_buffer: scoreboarded random/directed bench    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tilelink_channel_buffer;
    import tl_buf_pkg::*;

    localparam int A_DEPTH = 4;
    localparam int D_DEPTH = 4;
    localparam int MAX_OUT = 4;
`ifdef TL_BUF_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic a_valid_in, a_ready_in, a_valid_out, a_ready_out;
    logic d_valid_in, d_ready_in, d_valid_out, d_ready_out;
    logic [7:0]  outstanding, a_hwm, d_hwm;
    logic [15:0] a_stall_cnt;
    logic idle, err_unexpected_d, err_clr, perf_clr;
    tl_a_t a_drv, a_obs;
    tl_d_t d_drv, d_obs;

    tilelink_channel_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid_in(a_valid_in), .a_ready_in(a_ready_in),
        .a_opcode_in(a_drv.opcode), .a_param_in(a_drv.param), .a_size_in(a_drv.size),
        .a_source_in(a_drv.source), .a_address_in(a_drv.address),
        .a_mask_in(a_drv.mask), .a_data_in(a_drv.data),
        .a_valid_out(a_valid_out), .a_ready_out(a_ready_out),
        .a_opcode_out(a_obs.opcode), .a_param_out(a_obs.param), .a_size_out(a_obs.size),
        .a_source_out(a_obs.source), .a_address_out(a_obs.address),
        .a_mask_out(a_obs.mask), .a_data_out(a_obs.data),
        .d_valid_in(d_valid_in), .d_ready_in(d_ready_in),
        .d_opcode_in(d_drv.opcode), .d_param_in(d_drv.param), .d_size_in(d_drv.size),
        .d_source_in(d_drv.source), .d_sink_in(d_drv.sink), .d_data_in(d_drv.data),
        .d_error_in(d_drv.error),
        .d_valid_out(d_valid_out), .d_ready_out(d_ready_out),
        .d_opcode_out(d_obs.opcode), .d_param_out(d_obs.param), .d_size_out(d_obs.size),
        .d_source_out(d_obs.source), .d_sink_out(d_obs.sink), .d_data_out(d_obs.data),
        .d_error_out(d_obs.error),
        .outstanding(outstanding), .idle(idle),
        .err_unexpected_d(err_unexpected_d), .err_clr(err_clr), .perf_clr(perf_clr),
        .a_hwm(a_hwm), .d_hwm(d_hwm), .a_stall_cnt(a_stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: FIFO contents as queues, in-flight count, sticky error, perf stats.
    tl_a_t aq[$];
    tl_d_t dq[$];
    int    mo = 0;
    bit    merr = 1'b0;
    int    hwm_a = 0, hwm_d = 0, stall = 0;

    // Stimulus sources and knobs.
    tl_a_t a_src[$];
    tl_d_t d_src[$];
    int    a_rate = 100, d_rate = 100, a_rdy_rate = 100, d_rdy_rate = 100;
    bit    auto_resp = 1'b0;
    bit    a_fire_s = 1'b0, d_fire_s = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tl_a_t mk_a(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [1:0] src, input logic [31:0] data);
        tl_a_t p;
        p.opcode  = op;
        p.param   = 3'($urandom_range(0, 7));
        p.size    = 3'd2;
        p.source  = src;
        p.address = addr;
        p.mask    = 4'($urandom_range(1, 15));
        p.data    = data;
        return p;
    endfunction

    function automatic tl_d_t mk_d(input logic [1:0] src);
        tl_d_t p;
        p.opcode = 3'd1;
        p.param  = 3'd0;
        p.size   = 3'd2;
        p.source = src;
        p.sink   = 1'($urandom_range(0, 1));
        p.data   = $urandom;
        p.error  = ($urandom_range(0, 7) == 0);
        return p;
    endfunction

    // Driver: changes inputs on negedge, records fires just before the next posedge.
    initial begin
        a_valid_in = 1'b0; d_valid_in = 1'b0; a_ready_out = 1'b0; d_ready_out = 1'b0;
        a_drv = '0; d_drv = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                a_valid_in = 1'b0;
                d_valid_in = 1'b0;
            end else begin
                if (a_valid_in && a_fire_s) a_valid_in = 1'b0;
                if (d_valid_in && d_fire_s) d_valid_in = 1'b0;
                if (!a_valid_in && a_src.size() > 0 && $urandom_range(0, 99) < a_rate) begin
                    a_drv = a_src.pop_front();
                    a_valid_in = 1'b1;
                end
                if (!d_valid_in && d_src.size() > 0 && $urandom_range(0, 99) < d_rate) begin
                    d_drv = d_src.pop_front();
                    d_valid_in = 1'b1;
                end
                a_ready_out = ($urandom_range(0, 99) < a_rdy_rate);
                d_ready_out = ($urandom_range(0, 99) < d_rdy_rate);
            end
            #2;
            a_fire_s = a_valid_in && a_ready_in;
            d_fire_s = d_valid_in && d_ready_in;
            if (auto_resp && reset_n && a_valid_out && a_ready_out)
                d_src.push_back(mk_d(a_obs.source));
        end
    end

    // Monitor/scoreboard: compare status with the model, then apply the coming edge's fires.
    initial begin
        bit af, df;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                aq.delete(); dq.delete();
                mo = 0; merr = 1'b0; hwm_a = 0; hwm_d = 0; stall = 0;
                check("rst_a_valid_out", a_valid_out, 0);
                check("rst_d_valid_out", d_valid_out, 0);
                check("rst_a_ready_in", a_ready_in, 1);
                check("rst_d_ready_in", d_ready_in, 1);
                check("rst_outstanding", outstanding, 0);
                check("rst_idle", idle, 1);
                check("rst_err", err_unexpected_d, 0);
                check("rst_perf", {a_hwm, d_hwm, a_stall_cnt}, 0);
            end else begin
                check("a_valid_out", a_valid_out, (aq.size() > 0) && (mo < MAX_OUT));
                check("a_ready_in", a_ready_in, aq.size() < A_DEPTH);
                check("d_valid_out", d_valid_out, dq.size() > 0);
                check("d_ready_in", d_ready_in, dq.size() < D_DEPTH);
                check("outstanding", outstanding, mo);
                check("idle", idle, aq.size() == 0 && dq.size() == 0 && mo == 0);
                check("err_unexpected_d", err_unexpected_d, merr);
                check("a_hwm", a_hwm, PERF ? hwm_a : 0);
                check("d_hwm", d_hwm, PERF ? hwm_d : 0);
                check("a_stall_cnt", a_stall_cnt, PERF ? stall : 0);

                af = a_valid_out && a_ready_out;
                df = d_valid_out && d_ready_out;
                if (af) begin
                    if (aq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL a_beat: got an A output beat, expected none at %0t", $time);
                    end else check("a_fields", a_obs, aq.pop_front());
                end
                if (df) begin
                    if (dq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL d_beat: got a D output beat, expected none at %0t", $time);
                    end else check("d_fields", d_obs, dq.pop_front());
                end
                if (a_valid_in && a_ready_in) aq.push_back(a_drv);
                if (d_valid_in && d_ready_in) dq.push_back(d_drv);

                if (df && mo == 0) merr = 1'b1;
                else if (err_clr) merr = 1'b0;
                if (af && !df) mo++;
                else if (df && !af && mo > 0) mo--;

                if (perf_clr) begin
                    hwm_a = 0; hwm_d = 0; stall = 0;
                end else begin
                    if (aq.size() > hwm_a) hwm_a = aq.size();
                    if (dq.size() > hwm_d) hwm_d = dq.size();
                    if (a_valid_in && !a_ready_in && stall < 65535) stall++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(a_src.size() == 0 && d_src.size() == 0 && !a_valid_in && !d_valid_in &&
                 aq.size() == 0 && dq.size() == 0 && mo == 0) && n < 2000) begin
            cycles(1);
            n++;
        end
        cycles(2);
        check(name, n < 2000, 1);
    endtask

    initial begin
        err_clr = 1'b0;
        perf_clr = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        cycles(2);

        // Single Get
        a_src.push_back(mk_a(3'd4, 32'h1000_0040, 2'd2, 32'h0));
        cycles(4);
        check("get_outstanding", outstanding, 1);
        check("get_idle", idle, 0);
        d_src.push_back(mk_d(2'd2));
        wait_idle("get_drain");
        check("get_idle_after", idle, 1);

        // Fill A with downstream stalled, then drain
        a_rdy_rate = 0;
        for (int i = 0; i < 5; i++) a_src.push_back(mk_a(3'd0, 32'h2000 + 32'(i * 4), 2'(i), 32'(i)));
        cycles(10);
        check("full_ready_low", a_ready_in, 0);
        check("full_hwm", a_hwm, PERF ? 4 : 0);
        a_rdy_rate = 100;
        auto_resp = 1'b1;
        wait_idle("full_drain");

        // Limiter: responses withheld
        auto_resp = 1'b0;
        for (int i = 0; i < 5; i++) a_src.push_back(mk_a(3'd4, 32'h3000 + 32'(i * 4), 2'(i), 32'h0));
        cycles(12);
        check("lim_outstanding", outstanding, MAX_OUT);
        check("lim_valid_low", a_valid_out, 0);
        d_src.push_back(mk_d(2'd0));
        cycles(6);
        check("lim_after_d", outstanding, MAX_OUT);
        for (int i = 0; i < MAX_OUT; i++) d_src.push_back(mk_d(2'(i)));
        wait_idle("lim_drain");

        // Unexpected D response and error clear
        d_src.push_back(mk_d(2'd3));
        cycles(5);
        check("unexp_err", err_unexpected_d, 1);
        check("unexp_outstanding", outstanding, 0);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        cycles(2);
        check("err_cleared", err_unexpected_d, 0);

        // Streaming 100 beats, incrementing data
        auto_resp = 1'b1;
        for (int i = 0; i < 100; i++) a_src.push_back(mk_a(3'd0, 32'h4000, 2'(i), 32'(i)));
        wait_idle("stream_drain");

        // Randomised traffic with varying rates
        for (int r = 0; r < 3; r++) begin
            a_rate = $urandom_range(30, 100); d_rate = $urandom_range(30, 100);
            a_rdy_rate = $urandom_range(20, 100); d_rdy_rate = $urandom_range(20, 100);
            for (int i = 0; i < 60; i++)
                a_src.push_back(mk_a(3'($urandom_range(0, 4)), $urandom, 2'($urandom_range(0, 3)), $urandom));
            wait_idle("rand_drain");
        end

        // Perf clear
        perf_clr = 1'b1;
        cycles(1);
        perf_clr = 1'b0;
        cycles(1);
        check("perf_cleared", {a_hwm, d_hwm, a_stall_cnt}, 0);

        // Reset asserted mid-traffic
        a_rate = 100; d_rate = 100; a_rdy_rate = 50; d_rdy_rate = 100;
        for (int i = 0; i < 10; i++) a_src.push_back(mk_a(3'd0, 32'h5000, 2'(i), $urandom));
        cycles(6);
        auto_resp = 1'b0;
        a_src.delete();
        d_src.delete();
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        check("midrst_idle", idle, 1);
        a_rdy_rate = 100;
        auto_resp = 1'b1;
        for (int i = 0; i < 8; i++) a_src.push_back(mk_a(3'd4, 32'h6000, 2'(i), 32'h0));
        wait_idle("post_reset_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
